next_counter_generator: RTL and testbench
=========================================

NEXT_COUNTER_GENERATOR -- requirements
Module: next_counter_generator

Interface
REQ-001 Parameter WIDTH SHALL default to 5 and set the counter width in bits.
REQ-002 Parameter COUNTER_INIT SHALL default to 0 and set the value produced in the COUNT_INIT state.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the reset, synchronous and active-high.
REQ-005 Port counter, input, WIDTH bits, SHALL carry the current counter value.
REQ-006 Port counter_load, input, WIDTH bits, SHALL carry the value to load.
REQ-007 Port counter_load_en, input, 1 bit, SHALL request a load of counter_load when high.
REQ-008 Port count_state, input, 2 bits, SHALL select the operation: 00 COUNT_INIT, 01 COUNT_UP_EN, 10 COUNT_DOWN_EN, 11 COUNT_HOLD.
REQ-009 Port counter_n, output, WIDTH bits, SHALL carry the combinational next counter value.
REQ-010 Port counter_q, output, WIDTH bits, SHALL carry counter_n registered on clk.
REQ-011 Port at_max, output, 1 bit, SHALL be high when counter equals all-ones (combinational).
REQ-012 Port at_min, output, 1 bit, SHALL be high when counter equals zero (combinational).

Function
REQ-013 counter_n SHALL be purely combinational from counter, counter_load, counter_load_en and count_state, with zero-cycle latency and no dependence on clk or rst.
REQ-014 When counter_load_en=1, counter_n SHALL equal counter_load regardless of count_state.
REQ-015 When counter_load_en=0 and count_state=COUNT_INIT, counter_n SHALL equal COUNTER_INIT.
REQ-016 When counter_load_en=0 and count_state=COUNT_UP_EN, counter_n SHALL equal counter+1 modulo 2^WIDTH; all-ones wraps to 0.
REQ-017 When counter_load_en=0 and count_state=COUNT_DOWN_EN, counter_n SHALL equal counter-1 modulo 2^WIDTH; 0 wraps to all-ones.
REQ-018 When counter_load_en=0 and count_state=COUNT_HOLD, counter_n SHALL equal counter.
REQ-019 All arithmetic SHALL be performed in WIDTH bits with the carry/borrow discarded.
REQ-020 On each rising clk edge with rst=0, counter_q SHALL take the value of counter_n.
REQ-021 at_max and at_min SHALL depend only on counter, not on count_state or the load inputs.

Reset
REQ-022 When rst=1 at a rising clk edge, counter_q SHALL become COUNTER_INIT, overriding all other inputs.
REQ-023 rst SHALL NOT affect counter_n, at_max or at_min.
REQ-024 If reset is asserted mid-count, counter_q SHALL resume from COUNTER_INIT on the first edge after rst falls, using the counter_n value present then.

Structure
REQ-025 A shared package SHALL hold the count_state enum (COUNT_INIT, COUNT_UP_EN, COUNT_DOWN_EN, COUNT_HOLD) and the default WIDTH and COUNTER_INIT constants.
REQ-026 The combinational next-value mux SHALL be a single always_comb block with load priority ahead of the state case, and a default case arm that yields counter.
REQ-027 No sub-module is required; the output register and the flag logic SHALL live in the top module.

Verification
REQ-028 counter=00000, load_en=0, state=01 -> counter_n=00001; counter=11111, state=01 -> counter_n=00000 (wrap).
REQ-029 counter=11111, load_en=0, state=10 -> counter_n=11110; counter=00000, state=10 -> counter_n=11111 (wrap).
REQ-030 counter=11111, counter_load=10101, load_en=1, state=10 -> counter_n=10101 (load priority); the same with state=11 -> counter_n=10101.
REQ-031 counter=00001, load_en=0, state=00 -> counter_n=00000; state=11 -> counter_n=00001.
REQ-032 counter=00011, state=01, clock 3 edges with rst=0 -> counter_q=00100; assert rst for one edge -> counter_q=00000.
REQ-033 counter=11111 -> at_max=1, at_min=0; counter=00000 -> at_max=0, at_min=1.

Source files
------------

// File: rtl/next_counter_generator_pkg.sv
// Shared types and defaults for the next-counter generator.
// Holds the count_state encoding and the default width/init values.
package next_counter_generator_pkg;

  localparam int unsigned DEFAULT_WIDTH        = 5;
  localparam int unsigned DEFAULT_COUNTER_INIT = 0;

  typedef enum logic [1:0] {
    COUNT_INIT    = 2'b00,
    COUNT_UP_EN   = 2'b01,
    COUNT_DOWN_EN = 2'b10,
    COUNT_HOLD    = 2'b11
  } count_state_t;

endpackage

// File: rtl/next_counter_generator.sv
// Combinational next-value generator for a counter, with a registered
// copy of the next value and combinational min/max flags.
module next_counter_generator
  import next_counter_generator_pkg::*;
#(
  parameter int unsigned WIDTH        = DEFAULT_WIDTH,
  parameter int unsigned COUNTER_INIT = DEFAULT_COUNTER_INIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] counter,
  input  logic [WIDTH-1:0] counter_load,
  input  logic             counter_load_en,
  input  logic [1:0]       count_state,
  output logic [WIDTH-1:0] counter_n,
  output logic [WIDTH-1:0] counter_q,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(COUNTER_INIT);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  count_state_t state;
  assign state = count_state_t'(count_state);

  // Load wins over the state-selected operation; wrap is implicit
  // because the arithmetic stays in WIDTH bits.
  always_comb begin
    counter_n = counter;
    if (counter_load_en) begin
      counter_n = counter_load;
    end else begin
      case (state)
        COUNT_INIT:    counter_n = INIT_V;
        COUNT_UP_EN:   counter_n = counter + ONE;
        COUNT_DOWN_EN: counter_n = counter - ONE;
        COUNT_HOLD:    counter_n = counter;
        default:       counter_n = counter;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter_q <= INIT_V;
    end else begin
      counter_q <= counter_n;
    end
  end

  assign at_max = &counter;
  assign at_min = ~|counter;

endmodule

// File: tb/tb_next_counter_generator.sv
// Directed bench for next_counter_generator: combinational vector
// table plus hand-written register/reset sequences.
module tb_next_counter_generator;

  localparam int W = 5;

  logic         clk;
  logic         rst;
  logic [W-1:0] counter;
  logic [W-1:0] counter_load;
  logic         counter_load_en;
  logic [1:0]   count_state;
  logic [W-1:0] counter_n;
  logic [W-1:0] counter_q;
  logic         at_max;
  logic         at_min;

  int n_vec;
  int n_err;

  next_counter_generator #(
    .WIDTH(W),
    .COUNTER_INIT(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .counter(counter),
    .counter_load(counter_load),
    .counter_load_en(counter_load_en),
    .count_state(count_state),
    .counter_n(counter_n),
    .counter_q(counter_q),
    .at_max(at_max),
    .at_min(at_min)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] cnt;
    logic [W-1:0] load;
    logic         load_en;
    logic [1:0]   st;
    logic [W-1:0] exp_n;
    logic         exp_max;
    logic         exp_min;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    vecs[0]  = '{5'd0,  5'd0,  1'b0, 2'b01, 5'd1,  1'b0, 1'b1};
    vecs[1]  = '{5'd31, 5'd0,  1'b0, 2'b01, 5'd0,  1'b1, 1'b0};
    vecs[2]  = '{5'd31, 5'd0,  1'b0, 2'b10, 5'd30, 1'b1, 1'b0};
    vecs[3]  = '{5'd0,  5'd0,  1'b0, 2'b10, 5'd31, 1'b0, 1'b1};
    vecs[4]  = '{5'd31, 5'd21, 1'b1, 2'b10, 5'd21, 1'b1, 1'b0};
    vecs[5]  = '{5'd31, 5'd21, 1'b1, 2'b11, 5'd21, 1'b1, 1'b0};
    vecs[6]  = '{5'd1,  5'd0,  1'b0, 2'b00, 5'd0,  1'b0, 1'b0};
    vecs[7]  = '{5'd1,  5'd0,  1'b0, 2'b11, 5'd1,  1'b0, 1'b0};
    vecs[8]  = '{5'd10, 5'd7,  1'b1, 2'b00, 5'd7,  1'b0, 1'b0};
    vecs[9]  = '{5'd16, 5'd0,  1'b0, 2'b01, 5'd17, 1'b0, 1'b0};
    vecs[10] = '{5'd16, 5'd0,  1'b0, 2'b10, 5'd15, 1'b0, 1'b0};

    rst             = 1'b1;
    counter         = '0;
    counter_load    = '0;
    counter_load_en = 1'b0;
    count_state     = 2'b11;

    step();
    check("reset_q", 32'(counter_q), 32'd0);

    for (int i = 0; i < 11; i++) begin
      counter         = vecs[i].cnt;
      counter_load    = vecs[i].load;
      counter_load_en = vecs[i].load_en;
      count_state     = vecs[i].st;
      #1;
      check($sformatf("vec%0d_n", i), 32'(counter_n),
            32'(vecs[i].exp_n));
      check($sformatf("vec%0d_max", i), 32'(at_max),
            32'(vecs[i].exp_max));
      check($sformatf("vec%0d_min", i), 32'(at_min),
            32'(vecs[i].exp_min));
    end

    // Three edges counting up from a fixed counter of 3.
    @(negedge clk);
    rst             = 1'b0;
    counter         = 5'd3;
    counter_load    = '0;
    counter_load_en = 1'b0;
    count_state     = 2'b01;
    step();
    step();
    step();
    check("count3_q", 32'(counter_q), 32'd4);

    // Reset mid-count: counter_n and flags untouched, q returns to init.
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_n_indep", 32'(counter_n), 32'd4);
    check("rst_min_indep", 32'(at_min), 32'd0);
    step();
    check("rst_mid_q", 32'(counter_q), 32'd0);

    // Resume after reset picks up whatever counter_n is then.
    @(negedge clk);
    rst         = 1'b0;
    counter     = 5'd9;
    count_state = 2'b10;
    step();
    check("resume_q", 32'(counter_q), 32'd8);

    // Load registers through regardless of state.
    @(negedge clk);
    counter_load    = 5'd21;
    counter_load_en = 1'b1;
    count_state     = 2'b00;
    step();
    check("load_q", 32'(counter_q), 32'd21);

    // Up-count wrap registered.
    @(negedge clk);
    counter_load_en = 1'b0;
    counter         = 5'd31;
    count_state     = 2'b01;
    step();
    check("wrap_q", 32'(counter_q), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
